lsu_dmem: RTL

//  Load/store unit: the initiator side of the data-memory port. Sits between core execute stage and dmem.

---
 rtl/lsu_dmem.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/lsu_dmem.sv
// Load/store unit driving a word-wide data memory port.
// Byte/half stores use read-modify-write; loads are lane-extracted and extended.
module lsu_dmem #(
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        WE,
  output logic [31:0] A,
  output logic [31:0] WD,
  input  logic [31:0] RD
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW,
    S_STORE,
    S_RESP
  } state_e;

  state_e      state_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic        unsigned_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [31:0] a_q;
  logic [31:0] wd_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;

  logic        req_err_d;
  logic [32:0] addr_ext;
  logic [32:0] lo_ext;
  logic [32:0] hi_ext;
  logic [4:0]  lane_sh;
  logic [31:0] rd_shift;
  logic [31:0] lane_mask;
  logic [31:0] load_data_d;
  logic [31:0] merge_d;

  // Ready only while idle and not held in reset.
  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign WE         = we_q;
  assign A          = a_q;
  assign WD         = wd_q;

  // Classify the incoming request: illegal size, misalignment or out of range.
  always_comb begin
    addr_ext  = {1'b0, req_addr};
    lo_ext    = {1'b0, MEM_BASE};
    hi_ext    = lo_ext + 33'(MEM_BYTES);
    req_err_d = 1'b0;
    if (req_size == SZ_ILL)                                req_err_d = 1'b1;
    if ((req_size == SZ_HALF) && req_addr[0])              req_err_d = 1'b1;
    if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) req_err_d = 1'b1;
    if ((addr_ext < lo_ext) || (addr_ext >= hi_ext))       req_err_d = 1'b1;
  end

  // Lane extraction for loads and lane merge for sub-word stores, both off RD.
  always_comb begin
    lane_sh     = {lane_q, 3'b000};
    rd_shift    = RD >> lane_sh;
    load_data_d = RD;
    lane_mask   = 32'hFFFF_FFFF;
    case (size_q)
      SZ_BYTE: begin
        load_data_d = unsigned_q ? {24'h0, rd_shift[7:0]}
                                 : {{24{rd_shift[7]}}, rd_shift[7:0]};
        lane_mask   = 32'h0000_00FF << lane_sh;
      end
      SZ_HALF: begin
        load_data_d = unsigned_q ? {16'h0, rd_shift[15:0]}
                                 : {{16{rd_shift[15]}}, rd_shift[15:0]};
        lane_mask   = 32'h0000_FFFF << lane_sh;
      end
      default: begin
        load_data_d = RD;
        lane_mask   = 32'hFFFF_FFFF;
      end
    endcase
    merge_d = (RD & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
  end

  // Request sequencer; memory port and response outputs are all registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      wdata_q      <= 32'h0;
      we_q         <= 1'b0;
      a_q          <= 32'h0;
      wd_q         <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      we_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            size_q     <= req_size;
            lane_q     <= req_addr[1:0];
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata;
            if (req_err_d) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              a_q <= {req_addr[31:2], 2'b00};
              if (!req_we) begin
                state_q <= S_LOAD;
              end else if (req_size == SZ_WORD) begin
                state_q <= S_STORE;
                we_q    <= 1'b1;
                wd_q    <= req_wdata;
              end else begin
                state_q <= S_RMW;
              end
            end
          end
        end
        S_LOAD: begin
          resp_rdata_q <= load_data_d;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RMW: begin
          // WD doubles as the merge register for the following write cycle.
          wd_q    <= merge_d;
          we_q    <= 1'b1;
          state_q <= S_STORE;
        end
        S_STORE: begin
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
